if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage feeding the decode stage inside the core.
- Holds the PC, drives the synchronous instruction ROM port (one-cycle read latency) and registers {pc, instruction, valid} into the IF/ID boundary.
- Honours pipeline stall and branch redirect.
- Buffers a ROM response that returns during a stall, so no instruction is lost or duplicated.

Parameters:
- RESET_PC, 32'hBFC00000, first fetch address after reset.
- ADDR_W, 32, address / PC width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  decode stage cannot accept; hold outputs and do not issue a fetch.
- branch_flag  in  1  redirect request; honoured only when stall=0 (requester holds it until accepted).
- branch_target  in  ADDR_W  redirect address.
- rom_read_data  in  DATA_W  ROM data for the address presented on the previous cycle.
- rom_en  out  1  ROM read enable.
- rom_write_en  out  4  tied 4'b0000.
- rom_addr  out  ADDR_W  fetch address.
- rom_write_data  out  DATA_W  tied 0.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_pc  out  ADDR_W  PC of id_inst.
- id_inst  out  DATA_W  instruction; 0 (NOP) when id_adel=1.
- id_adel  out  1  fetch address misaligned (pc[1:0]!=0).

Behaviour:
- Reset (rst=1 at an edge):
  - pc_q=RESET_PC; req_pending=0, req_pc=0, req_adel=0; buf_valid=0, buf_inst=0.
  - id_valid=0, id_pc=0, id_inst=0, id_adel=0.
  - Combinational outputs while rst=1: rom_en=0, rom_addr=pc_q.
  - Reset mid-stall or mid-redirect discards everything; the first fetch after release is RESET_PC.
- Issue (combinational), when rst=0 and stall=0:
  - fetch address A = branch_flag ? branch_target : pc_q.
  - rom_addr=A.
  - rom_en=1 if A[1:0]==0; rom_en=0 if misaligned.
- Issue (combinational), when stall=1:
  - rom_en=0, rom_addr=pc_q.
- Issue (next edge), when stall=0:
  - pc_q<=A+4 (wraps modulo 2^ADDR_W).
  - req_pending<=1, req_pc<=A, req_adel<=(A[1:0]!=0).
- Response, stall=0, no redirect:
  - id_valid<=req_pending; id_pc<=req_pc; id_adel<=req_adel.
  - id_inst<= req_adel ? 0 : (buf_valid ? buf_inst : rom_read_data).
  - buf_valid<=0.
  - When req_pending=0, id_pc/id_inst/id_adel hold their values.
- Response, stall=0, branch_flag=1:
  - The arriving response is wrong-path: id_valid<=0, buf_valid<=0.
  - id_pc/id_inst/id_adel hold their values.
  - The new request to branch_target is issued the same cycle.
  - Redirect penalty: exactly one bubble.
- Stall=1:
  - pc_q, req_pending, req_pc, req_adel and all id_* outputs hold.
  - If req_pending=1 and buf_valid=0: buf_inst<=rom_read_data, buf_valid<=1 (captures data exactly one cycle after the issue edge).
  - Further stall cycles leave buf unchanged; ROM output drift is ignored.
- Stall release: the buffered instruction is presented (buf_valid path) while the next fetch issues in the same cycle. Steady-state throughput: one instruction per cycle.
- branch_flag while stall=1 has no effect.
- Latency: address issued at edge N appears on id_* after edge N+1 (one cycle), plus one cycle for each stall cycle in between.

Test Plan:
- Reset then free-run, ROM[i]=i:
  - rom_addr sequence BFC00000, BFC00004, ….
  - id_valid first rises one cycle after the first rom_en.
  - id_pc/id_inst = (BFC00000, ROM word), then +4 every cycle, no gaps.
- Stall for 3 cycles right after fetching BFC00008, ROM output forced to garbage while rom_en=0:
  - id_* holds BFC00004.
  - After release, id_pc=BFC00008 with the correct word, then BFC0000C; no duplicates, no skips.
- branch_flag=1, branch_target=BFC00100 while id_pc=BFC00004:
  - Next cycle id_valid=0.
  - Following cycle id_pc=BFC00100.
  - Then BFC00104.
- branch_flag=1 held during stall=1 for 2 cycles:
  - No redirect while stalled.
  - Redirect occurs in the first cycle with stall=0; the buffered instruction is dropped (id_valid=0), then id_pc=target.
- branch_target=BFC00102:
  - rom_en=0 that cycle.
  - Next cycle id_valid=1, id_adel=1, id_inst=0, id_pc=BFC00102.
  - Following fetch is BFC00106 with id_adel=1.
- Assert rst during a stall with buf_valid=1:
  - All outputs return to reset values.
  - First fetch after release is BFC00000.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch with stall buffering and branch redirect into the IF/ID register
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [DATA_W-1:0] rom_read_data,
   output logic              rom_en,
   output logic [3:0]        rom_write_en,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [DATA_W-1:0] rom_write_data,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [DATA_W-1:0] id_inst,
   output logic              id_adel
);
   logic [ADDR_W-1:0] pc_q, req_pc, fetch_addr;
   logic              req_pending, req_adel, buf_valid;
   logic [DATA_W-1:0] buf_inst;
   // fetch address selection and ROM port drive
   always_comb begin
      fetch_addr     = branch_flag ? branch_target : pc_q;
      rom_en         = !rst && !stall && fetch_addr[1:0] == 2'b00;
      rom_addr       = (rst || stall) ? pc_q : fetch_addr;
      rom_write_en   = 4'b0000;
      rom_write_data = '0;
   end
   // PC, outstanding request, stall buffer and IF/ID register
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= ADDR_W'(RESET_PC);
         req_pending <= 1'b0;
         req_pc      <= '0;
         req_adel    <= 1'b0;
         buf_valid   <= 1'b0;
         buf_inst    <= '0;
         id_valid    <= 1'b0;
         id_pc       <= '0;
         id_inst     <= '0;
         id_adel     <= 1'b0;
      end else if (!stall) begin
         pc_q        <= fetch_addr + ADDR_W'(4);
         req_pending <= 1'b1;
         req_pc      <= fetch_addr;
         req_adel    <= fetch_addr[1:0] != 2'b00;
         buf_valid   <= 1'b0;
         id_valid    <= req_pending && !branch_flag;
         if (req_pending && !branch_flag) begin
            id_pc   <= req_pc;
            id_adel <= req_adel;
            id_inst <= req_adel ? '0 : (buf_valid ? buf_inst : rom_read_data);
         end
      end else if (req_pending && !buf_valid) begin
         buf_inst  <= rom_read_data;
         buf_valid <= 1'b1;
      end
   end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed check of if_stage against a transaction-level fetch model
module tb_if_stage;
   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, branch_flag = 1'b0;
   logic [31:0] branch_target = '0, rom_read_data = '0;
   logic        rom_en, id_valid, id_adel;
   logic [3:0]  rom_write_en;
   logic [31:0] rom_addr, rom_write_data, id_pc, id_inst;
   int          n_cmp = 0, n_bad = 0;
   logic        known = 1'b0;
   logic [31:0] m_pc = 32'hBFC00000, m_req = '0;
   logic        m_pend = 1'b0;
   logic        e_valid = 1'b0, e_adel = 1'b0;
   logic [31:0] e_pc = '0, e_inst = '0;

   if_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
      .branch_target(branch_target), .rom_read_data(rom_read_data),
      .rom_en(rom_en), .rom_write_en(rom_write_en), .rom_addr(rom_addr),
      .rom_write_data(rom_write_data), .id_valid(id_valid), .id_pc(id_pc),
      .id_inst(id_inst), .id_adel(id_adel)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {2'b00, a[31:2]};
   endfunction

   // synchronous ROM: garbage whenever not enabled
   always @(posedge clk) rom_read_data <= rom_en ? word(rom_addr) : $urandom;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
      logic [31:0] a;
      rst = r; stall = s; branch_flag = b; branch_target = t;
      @(negedge clk);
      a = b ? t : m_pc;
      if (known) begin
         check("rom_en", 32'(rom_en), 32'(!r && !s && a[1:0] == 2'b00));
         check("rom_addr", rom_addr, (r || s) ? m_pc : a);
         check("rom_write_en", 32'(rom_write_en), 32'd0);
         check("rom_write_data", rom_write_data, 32'd0);
         check("id_valid", 32'(id_valid), 32'(e_valid));
         check("id_pc", id_pc, e_pc);
         check("id_inst", id_inst, e_inst);
         check("id_adel", 32'(id_adel), 32'(e_adel));
      end
      if (r) begin
         known = 1'b1; m_pc = 32'hBFC00000; m_pend = 1'b0;
         e_valid = 1'b0; e_pc = '0; e_inst = '0; e_adel = 1'b0;
      end else if (!s) begin
         e_valid = m_pend && !b;
         if (e_valid) begin
            e_pc = m_req;
            e_adel = m_req[1:0] != 2'b00;
            e_inst = e_adel ? 32'd0 : word(m_req);
         end
         m_pend = 1'b1; m_req = a; m_pc = a + 32'd4;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      // free run
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      check("lit_first_valid", 32'(id_valid), 32'd1);
      check("lit_first_pc", id_pc, 32'hBFC00000);
      check("lit_first_inst", id_inst, 32'h2FF00000);
      step(0, 0, 0, 0);
      // BFC00008 issued above; stall three cycles
      step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
      check("lit_stall_pc", id_pc, 32'hBFC00004);
      step(0, 0, 0, 0);
      check("lit_release_pc", id_pc, 32'hBFC00008);
      check("lit_release_inst", id_inst, 32'h2FF00002);
      step(0, 0, 0, 0);
      check("lit_after_release_pc", id_pc, 32'hBFC0000C);
      // redirect
      step(0, 0, 1, 32'hBFC00100);
      check("lit_bubble", 32'(id_valid), 32'd0);
      step(0, 0, 0, 0);
      check("lit_target_pc", id_pc, 32'hBFC00100);
      step(0, 0, 0, 0);
      check("lit_target_next", id_pc, 32'hBFC00104);
      // redirect held during stall
      step(0, 1, 1, 32'hBFC00200); step(0, 1, 1, 32'hBFC00200);
      step(0, 0, 1, 32'hBFC00200);
      check("lit_drop_buffered", 32'(id_valid), 32'd0);
      step(0, 0, 0, 0);
      check("lit_stalled_target", id_pc, 32'hBFC00200);
      // misaligned target
      step(0, 0, 1, 32'hBFC00102);
      step(0, 0, 0, 0);
      check("lit_adel", 32'(id_adel), 32'd1);
      check("lit_adel_inst", id_inst, 32'd0);
      check("lit_adel_pc", id_pc, 32'hBFC00102);
      step(0, 0, 0, 0);
      check("lit_adel_next", id_pc, 32'hBFC00106);
      // reset while a buffered response is held
      step(0, 0, 1, 32'hBFC00300); step(0, 1, 0, 0); step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      check("lit_rst_valid", 32'(id_valid), 32'd0);
      check("lit_rst_pc", id_pc, 32'd0);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      check("lit_rst_refetch", id_pc, 32'hBFC00000);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         t = 32'hBFC00000 + {$urandom_range(0, 1023), 2'b00};
         if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom);
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 15, t);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
